// File: rtl/weight_fetch_seq_if.sv
// -----------------------------------------------------------------------------
// weight_fetch_seq_if
//   Bus between the weight fetch sequencer and the weight memory interface.
//
//   Signals:
//     mem_addr          sequencer -> memory  word address of the current read
//     mem_read_weights  sequencer -> memory  read strobe, one word per cycle
//     mem_weight_in     memory -> sequencer  registered read data; it belongs
//                                            to the read presented one cycle
//                                            earlier
//
//   Handshake: there is no back-pressure. Every cycle with mem_read_weights=1
//   is one accepted read of mem_addr, and its data must appear on
//   mem_weight_in in the following cycle. Outside those cycles mem_weight_in
//   carries no meaning.
//
//   Modports:
//     master  the sequencer side
//     slave   the memory side
// -----------------------------------------------------------------------------
interface weight_fetch_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_weights;
  logic [DATA_W-1:0] mem_weight_in;

  modport master (
    output mem_addr,
    output mem_read_weights,
    input  mem_weight_in
  );

  modport slave (
    input  mem_addr,
    input  mem_read_weights,
    output mem_weight_in
  );
endinterface

// File: rtl/weight_fetch_seq.sv
// -----------------------------------------------------------------------------
// weight_fetch_seq
//   Reads ARRAY_N*ARRAY_N consecutive weight words from the weight memory
//   interface and assembles them into one tile for the systolic array.
//
//   Ports:
//     clk, rst       clock; synchronous active-high reset
//     start          one-cycle fetch request, only honoured in IDLE
//     base_addr      address of tile word 0, captured together with start
//     mem            weight memory bus (master side)
//     weights_flat   tile, slot s at [(s+1)*DATA_W-1 : s*DATA_W]
//     weights_valid  high while weights_flat holds a complete tile
//     busy           high in FETCH and DRAIN
//     done           one-cycle pulse in the cycle the tile completes
//     dbg_state_o    current FSM state (IDLE=0, FETCH=1, DRAIN=2, DONE=3)
//
//   Handshake: start and done are single-cycle pulses with no ready
//   signal; a start that arrives while the sequencer is not IDLE is dropped.
//
//   Configuration macro: WEIGHT_TRANSPOSE_EN
//     undefined  word k lands in slot k (row-major tile)
//     defined    word k (row k/ARRAY_N, col k%ARRAY_N) lands in slot
//                col*ARRAY_N+row (column-major tile)
// -----------------------------------------------------------------------------
module weight_fetch_seq #(
  parameter int DATA_W  = 8,
  parameter int ARRAY_N = 2,
  parameter int ADDR_W  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [ADDR_W-1:0]                  base_addr,
  weight_fetch_seq_if.master                 mem,
  output logic [ARRAY_N*ARRAY_N*DATA_W-1:0]  weights_flat,
  output logic                               weights_valid,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         dbg_state_o
);

  localparam int NN     = ARRAY_N * ARRAY_N;
  localparam int CNT_W  = $clog2(NN + 1);
  localparam int TILE_W = NN * DATA_W;

  localparam logic [CNT_W-1:0] NN_C   = CNT_W'(NN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                rd_dly_q, rd_dly_d;   // read strobe delayed to the data cycle
  logic [CNT_W-1:0]    issue_q, issue_d;     // reads presented so far
  logic [CNT_W-1:0]    cap_q, cap_d;         // index of the next word to capture
  logic [TILE_W-1:0]   flat_q, flat_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Tile slot that word k is written to.
  function automatic int slot_of(input logic [CNT_W-1:0] k);
`ifdef WEIGHT_TRANSPOSE_EN
    int row;
    int col;
    row = int'(k) / ARRAY_N;
    col = int'(k) % ARRAY_N;
    return col * ARRAY_N + row;
`else
    return int'(k);
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      rd_dly_q <= 1'b0;
      issue_q  <= '0;
      cap_q    <= '0;
      flat_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      rd_dly_q <= rd_dly_d;
      issue_q  <= issue_d;
      cap_q    <= cap_d;
      flat_q   <= flat_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    rd_dly_d = rd_q;
    issue_d  = issue_q;
    cap_d    = cap_q;
    flat_d   = flat_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // The memory registers its output, so the word for a read presented
    // last cycle is on mem_weight_in now. Anything seen outside these
    // cycles is stale and never captured.
    if (rd_dly_q) begin
      flat_d[slot_of(cap_q)*DATA_W +: DATA_W] = mem.mem_weight_in;
      cap_d = cap_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = base_addr;
          rd_d    = 1'b1;
          issue_d = CNT_W'(1);
          cap_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        if (issue_q == NN_C) begin
          rd_d    = 1'b0;
          state_d = DRAIN;
        end else begin
          // Wraps modulo 2^ADDR_W by construction.
          addr_d  = addr_q + ADDR_W'(1);
          issue_d = issue_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (rd_dly_q && (cap_q == LAST_C)) begin
          state_d = DONE;
          done_d  = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem.mem_addr         = addr_q;
  assign mem.mem_read_weights = rd_q;
  assign weights_flat         = flat_q;
  assign weights_valid        = valid_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign dbg_state_o          = state_q;

endmodule
